// File: rtl/rs_issue_sched_if.sv
// Issue bus between the RS array and rs_issue_sched: per-entry wake-ups in, per-slot grants out.
// master = scheduler side, slave = RS array / FU issue side.
interface rs_issue_sched_if #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int N_ALU   = 2
);
    logic [RS_SIZE-1:0]     wake_alu;
    logic [RS_SIZE-1:0]     wake_mul;
    logic [RS_SIZE-1:0]     wake_mem;
    logic [RS_SIZE-1:0]     wake_bcond;
    logic                   mem_stall;
    logic                   flush;
    logic [RS_SIZE-1:0]     rs_use_en;
    logic [N_ALU-1:0]       alu_valid;
    logic [N_ALU*IDX_W-1:0] alu_idx;
    logic                   mul_valid;
    logic [IDX_W-1:0]       mul_idx;
    logic                   mem_valid;
    logic [IDX_W-1:0]       mem_idx;
    logic                   bcond_valid;
    logic [IDX_W-1:0]       bcond_idx;
    logic                   mul_busy;

    modport master (
        input  wake_alu, wake_mul, wake_mem, wake_bcond, mem_stall, flush,
        output rs_use_en, alu_valid, alu_idx, mul_valid, mul_idx,
               mem_valid, mem_idx, bcond_valid, bcond_idx, mul_busy
    );

    modport slave (
        output wake_alu, wake_mul, wake_mem, wake_bcond, mem_stall, flush,
        input  rs_use_en, alu_valid, alu_idx, mul_valid, mul_idx,
               mem_valid, mem_idx, bcond_valid, bcond_idx, mul_busy
    );
endinterface

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: per-class round-robin select of N_ALU ALU, 1 MUL, 1 MEM, 1 BCOND.
// Optional macro RS_SCHED_FIXED_PRIO_EN replaces round-robin with lowest-index-first selection.
module rs_issue_sched #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int N_ALU   = 2,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    rs_issue_sched_if.master bus
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester at or after base, wrapping around the array.
    function automatic pick_t rr_pick(input logic [RS_SIZE-1:0] req, input logic [IDX_W-1:0] base);
        pick_t res;
        int    pos;
        res = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            pos = (int'(base) + i) % RS_SIZE;
            if (!res.found && req[pos]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(pos);
            end
        end
        return res;
    endfunction

    logic [N_ALU-1:0]       alu_valid_reg;
    logic [N_ALU*IDX_W-1:0] alu_idx_reg;
    logic                   mul_valid_reg;
    logic [IDX_W-1:0]       mul_idx_reg;
    logic                   mem_valid_reg;
    logic [IDX_W-1:0]       mem_idx_reg;
    logic                   bcond_valid_reg;
    logic [IDX_W-1:0]       bcond_idx_reg;
    logic [CNT_W-1:0]       mul_cnt_reg;

    logic [N_ALU-1:0]       alu_valid_next;
    logic [N_ALU*IDX_W-1:0] alu_idx_next;
    logic                   mul_valid_next;
    logic [IDX_W-1:0]       mul_idx_next;
    logic                   mem_valid_next;
    logic [IDX_W-1:0]       mem_idx_next;
    logic                   bcond_valid_next;
    logic [IDX_W-1:0]       bcond_idx_next;

    logic [RS_SIZE-1:0]     use_en;
    logic [RS_SIZE-1:0]     taken_next;
    logic                   mul_busy;
    logic [IDX_W-1:0]       base_alu;
    logic [IDX_W-1:0]       base_mul;
    logic [IDX_W-1:0]       base_mem;
    logic [IDX_W-1:0]       base_bcond;

    assign mul_busy = (mul_cnt_reg != '0);

    // Classes are resolved in priority order; each later class only sees entries
    // not issuing this cycle and not already taken by an earlier slot.
    always_comb begin
        pick_t              p;
        logic [RS_SIZE-1:0] avail;
        avail            = ~use_en;
        taken_next       = '0;
        alu_valid_next   = '0;
        alu_idx_next     = '0;
        mul_valid_next   = 1'b0;
        mul_idx_next     = '0;
        mem_valid_next   = 1'b0;
        mem_idx_next     = '0;
        bcond_valid_next = 1'b0;
        bcond_idx_next   = '0;

        for (int k = 0; k < N_ALU; k++) begin
            p = rr_pick(bus.wake_alu & avail & ~taken_next, base_alu);
            if (p.found) begin
                alu_valid_next[k]              = 1'b1;
                alu_idx_next[k*IDX_W +: IDX_W] = p.idx;
                taken_next[p.idx]              = 1'b1;
            end
        end

        p = rr_pick(bus.wake_mul & avail & ~taken_next, base_mul);
        if (p.found && !mul_busy) begin
            mul_valid_next    = 1'b1;
            mul_idx_next      = p.idx;
            taken_next[p.idx] = 1'b1;
        end

        p = rr_pick(bus.wake_mem & avail & ~taken_next, base_mem);
        if (p.found && !bus.mem_stall) begin
            mem_valid_next    = 1'b1;
            mem_idx_next      = p.idx;
            taken_next[p.idx] = 1'b1;
        end

        p = rr_pick(bus.wake_bcond & avail & ~taken_next, base_bcond);
        if (p.found) begin
            bcond_valid_next  = 1'b1;
            bcond_idx_next    = p.idx;
            taken_next[p.idx] = 1'b1;
        end
    end

`ifndef RS_SCHED_FIXED_PRIO_EN
    logic [IDX_W-1:0] ptr_alu_reg;
    logic [IDX_W-1:0] ptr_mul_reg;
    logic [IDX_W-1:0] ptr_mem_reg;
    logic [IDX_W-1:0] ptr_bcond_reg;
    logic [IDX_W-1:0] alu_last;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] winner);
        return IDX_W'((int'(winner) + 1) % RS_SIZE);
    endfunction

    // The ALU pointer moves past the highest-numbered slot that won.
    always_comb begin
        alu_last = '0;
        for (int k = 0; k < N_ALU; k++) begin
            if (alu_valid_next[k]) alu_last = alu_idx_next[k*IDX_W +: IDX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_alu_reg   <= '0;
            ptr_mul_reg   <= '0;
            ptr_mem_reg   <= '0;
            ptr_bcond_reg <= '0;
        end else if (!bus.flush) begin
            if (|alu_valid_next)  ptr_alu_reg   <= next_ptr(alu_last);
            if (mul_valid_next)   ptr_mul_reg   <= next_ptr(mul_idx_next);
            if (mem_valid_next)   ptr_mem_reg   <= next_ptr(mem_idx_next);
            if (bcond_valid_next) ptr_bcond_reg <= next_ptr(bcond_idx_next);
        end
    end

    assign base_alu   = ptr_alu_reg;
    assign base_mul   = ptr_mul_reg;
    assign base_mem   = ptr_mem_reg;
    assign base_bcond = ptr_bcond_reg;
`else
    assign base_alu   = '0;
    assign base_mul   = '0;
    assign base_mem   = '0;
    assign base_bcond = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            alu_valid_reg   <= '0;
            alu_idx_reg     <= '0;
            mul_valid_reg   <= 1'b0;
            mul_idx_reg     <= '0;
            mem_valid_reg   <= 1'b0;
            mem_idx_reg     <= '0;
            bcond_valid_reg <= 1'b0;
            bcond_idx_reg   <= '0;
        end else begin
            alu_valid_reg   <= alu_valid_next;
            alu_idx_reg     <= alu_idx_next;
            mul_valid_reg   <= mul_valid_next;
            mul_idx_reg     <= mul_idx_next;
            mem_valid_reg   <= mem_valid_next;
            mem_idx_reg     <= mem_idx_next;
            bcond_valid_reg <= bcond_valid_next;
            bcond_idx_reg   <= bcond_idx_next;
        end
    end

    // Non-pipelined multiplier: a grant is only possible with the counter at zero.
    always_ff @(posedge clk) begin
        if (rst || bus.flush)          mul_cnt_reg <= '0;
        else if (mul_valid_next)       mul_cnt_reg <= CNT_W'(MUL_LAT - 1);
        else if (mul_cnt_reg != '0)    mul_cnt_reg <= mul_cnt_reg - CNT_W'(1);
    end

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_use_dec
            logic alu_hit;
            always_comb begin
                alu_hit = 1'b0;
                for (int k = 0; k < N_ALU; k++) begin
                    if (alu_valid_reg[k] && alu_idx_reg[k*IDX_W +: IDX_W] == IDX_W'(gi)) alu_hit = 1'b1;
                end
            end
            assign use_en[gi] = alu_hit
                              | (mul_valid_reg   && mul_idx_reg   == IDX_W'(gi))
                              | (mem_valid_reg   && mem_idx_reg   == IDX_W'(gi))
                              | (bcond_valid_reg && bcond_idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign bus.rs_use_en   = use_en;
    assign bus.alu_valid   = alu_valid_reg;
    assign bus.alu_idx     = alu_idx_reg;
    assign bus.mul_valid   = mul_valid_reg;
    assign bus.mul_idx     = mul_idx_reg;
    assign bus.mem_valid   = mem_valid_reg;
    assign bus.mem_idx     = mem_idx_reg;
    assign bus.bcond_valid = bcond_valid_reg;
    assign bus.bcond_idx   = bcond_idx_reg;
    assign bus.mul_busy    = mul_busy;
endmodule

// File: tb/tb_rs_issue_sched.sv
// Self-checking bench for rs_issue_sched: constant vectors, corner sequences and a randomized run
// against a reference model built from the selection rules.
module tb_rs_issue_sched;
    localparam int MUL_LAT = 4;

    logic clk;
    logic rst;

    rs_issue_sched_if #(.RS_SIZE(16), .IDX_W(4), .N_ALU(2)) bus ();
    rs_issue_sched_if #(.RS_SIZE(16), .IDX_W(4), .N_ALU(1)) bus1 ();

    rs_issue_sched #(.RS_SIZE(16), .IDX_W(4), .N_ALU(2), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    rs_issue_sched #(.RS_SIZE(16), .IDX_W(4), .N_ALU(1), .MUL_LAT(MUL_LAT)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] wa, wm, we, wb, input logic st, fl);
        bus.wake_alu   = wa;
        bus.wake_mul   = wm;
        bus.wake_mem   = we;
        bus.wake_bcond = wb;
        bus.mem_stall  = st;
        bus.flush      = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus1.wake_alu = 16'h0; bus1.wake_mul = 16'h0; bus1.wake_mem = 16'h0;
        bus1.wake_bcond = 16'h0; bus1.mem_stall = 1'b0; bus1.flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] wa, wm, we, wb;
        logic        st, fl;
        logic [1:0]  av;
        logic [7:0]  ai;
        logic        mv;
        logic [3:0]  mi;
        logic        mev;
        logic [3:0]  mei;
        logic        bv;
        logic [3:0]  bi;
        logic [15:0] use_en;
        logic        busy;
    } vec_t;

    // ---------------- reference model ----------------
    int          m_ptr [4];
    int          m_cnt;
    logic [15:0] m_use;
    logic [15:0] e_use;
    logic [1:0]  e_av;
    logic [7:0]  e_ai;
    logic        e_mv, e_mev, e_bv, e_busy;
    logic [3:0]  e_mi, e_mei, e_bi;

    function automatic int scan_base(input int cls);
        int b;
        b = m_ptr[cls];
`ifdef RS_SCHED_FIXED_PRIO_EN
        b = 0;
`endif
        return b;
    endfunction

    function automatic int first_from(input logic [15:0] req, input int start);
        for (int off = 0; off < 16; off++) begin
            if (req[(start + off) % 16]) return (start + off) % 16;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] wa, wm, we, wb, input logic st, fl, r);
        logic [15:0] free;
        int w, last, mul_w, mem_w, b_w;
        e_av = '0; e_ai = '0; e_mv = 1'b0; e_mi = '0;
        e_mev = 1'b0; e_mei = '0; e_bv = 1'b0; e_bi = '0;
        if (r) begin
            m_ptr = '{0, 0, 0, 0};
            m_cnt = 0;
        end else begin
            free = ~m_use;
            last = -1;
            for (int s = 0; s < 2; s++) begin
                w = first_from(wa & free, scan_base(0));
                if (w >= 0) begin
                    e_av[s] = 1'b1; e_ai[s*4 +: 4] = 4'(w); free[w] = 1'b0; last = w;
                end
            end
            mul_w = (m_cnt == 0) ? first_from(wm & free, scan_base(1)) : -1;
            if (mul_w >= 0) begin e_mv = 1'b1; e_mi = 4'(mul_w); free[mul_w] = 1'b0; end
            mem_w = st ? -1 : first_from(we & free, scan_base(2));
            if (mem_w >= 0) begin e_mev = 1'b1; e_mei = 4'(mem_w); free[mem_w] = 1'b0; end
            b_w = first_from(wb & free, scan_base(3));
            if (b_w >= 0) begin e_bv = 1'b1; e_bi = 4'(b_w); end
            if (fl) begin
                e_av = '0; e_ai = '0; e_mv = 1'b0; e_mi = '0;
                e_mev = 1'b0; e_mei = '0; e_bv = 1'b0; e_bi = '0;
                m_cnt = 0;
            end else begin
                if (last >= 0)  m_ptr[0] = (last + 1) % 16;
                if (mul_w >= 0) m_ptr[1] = (mul_w + 1) % 16;
                if (mem_w >= 0) m_ptr[2] = (mem_w + 1) % 16;
                if (b_w >= 0)   m_ptr[3] = (b_w + 1) % 16;
                m_cnt = (mul_w >= 0) ? MUL_LAT - 1 : ((m_cnt > 0) ? m_cnt - 1 : 0);
            end
        end
        e_use = '0;
        if (e_av[0]) e_use[e_ai[3:0]] = 1'b1;
        if (e_av[1]) e_use[e_ai[7:4]] = 1'b1;
        if (e_mv)    e_use[e_mi]      = 1'b1;
        if (e_mev)   e_use[e_mei]     = 1'b1;
        if (e_bv)    e_use[e_bi]      = 1'b1;
        e_busy = (m_cnt != 0);
        m_use  = e_use;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        logic [15:0] ra, rm, re, rb;
        logic        rst_r, st_r, fl_r;
        int          prev_idx;

        vecs[0] = '{16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b11, 8'h20, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0005, 1'b0};
        vecs[1] = '{16'h0008, 16'h0000, 16'h0008, 16'h0000, 1'b0, 1'b0, 2'b01, 8'h03, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0008, 1'b0};
        vecs[2] = '{16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0001, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0010, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 16'h0010, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0010, 16'h0000, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h0000, 1'b0};
        vecs[6] = '{16'h0007, 16'h0006, 16'h000C, 16'h0018, 1'b0, 1'b0, 2'b11, 8'h10, 1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 4'h4, 16'h001F, 1'b1};
        vecs[7] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0, 2'b01, 8'h0F, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 16'h8000, 1'b0};
        vecs[8] = '{16'h0000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 4'hE, 16'hC000, 1'b1};
        vecs[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h8, 16'h0100, 1'b0};

        rst = 1'b1;
        do_reset();
        check("reset_use_en", bus.rs_use_en, 32'h0);
        check("reset_alu_valid", bus.alu_valid, 32'h0);
        check("reset_mul_busy", bus.mul_busy, 32'h0);
        check("reset_slot_valids", {bus.mul_valid, bus.mem_valid, bus.bcond_valid}, 32'h0);

        // ---------------- table-driven vectors, each from a fresh reset ----------------
        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive(vecs[i].wa, vecs[i].wm, vecs[i].we, vecs[i].wb, vecs[i].st, vecs[i].fl);
            tick();
            drive(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            $display("vec %0d: alu_v=%b alu_idx=%h mul=%b/%h mem=%b/%h bcond=%b/%h use=%h busy=%b", i,
                     bus.alu_valid, bus.alu_idx, bus.mul_valid, bus.mul_idx, bus.mem_valid, bus.mem_idx,
                     bus.bcond_valid, bus.bcond_idx, bus.rs_use_en, bus.mul_busy);
            check($sformatf("vec%0d_alu_valid", i), bus.alu_valid, vecs[i].av);
            check($sformatf("vec%0d_alu_idx", i), bus.alu_idx, vecs[i].ai);
            check($sformatf("vec%0d_mul", i), {bus.mul_valid, bus.mul_idx}, {vecs[i].mv, vecs[i].mi});
            check($sformatf("vec%0d_mem", i), {bus.mem_valid, bus.mem_idx}, {vecs[i].mev, vecs[i].mei});
            check($sformatf("vec%0d_bcond", i), {bus.bcond_valid, bus.bcond_idx}, {vecs[i].bv, vecs[i].bi});
            check($sformatf("vec%0d_use_en", i), bus.rs_use_en, vecs[i].use_en);
            check($sformatf("vec%0d_mul_busy", i), bus.mul_busy, vecs[i].busy);
            tick();
            check($sformatf("vec%0d_after_use_en", i), bus.rs_use_en, 32'h0);
            check($sformatf("vec%0d_after_valids", i),
                  {bus.alu_valid, bus.mul_valid, bus.mem_valid, bus.bcond_valid}, 32'h0);
        end

        // ---------------- MUL occupancy ----------------
        do_reset();
        drive(16'h0, 16'h0003, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        $display("mul seq: grant mul=%b/%h busy=%b", bus.mul_valid, bus.mul_idx, bus.mul_busy);
        check("mul_first_grant", {bus.mul_valid, bus.mul_idx}, {1'b1, 4'h0});
        check("mul_busy_c1", bus.mul_busy, 32'h1);
        for (int c = 2; c <= 4; c++) begin
            drive(16'h0, 16'h0002, 16'h0, 16'h0, 1'b0, 1'b0);
            tick();
            $display("mul seq: cycle %0d mul_valid=%b busy=%b", c, bus.mul_valid, bus.mul_busy);
            check($sformatf("mul_hold_valid_c%0d", c), bus.mul_valid, 32'h0);
            check($sformatf("mul_busy_c%0d", c), bus.mul_busy, (c < 4) ? 32'h1 : 32'h0);
        end
        tick();
        $display("mul seq: second grant mul=%b/%h", bus.mul_valid, bus.mul_idx);
        check("mul_second_grant", {bus.mul_valid, bus.mul_idx}, {1'b1, 4'h1});
        check("mul_busy_again", bus.mul_busy, 32'h1);

        // ---------------- MEM stall ----------------
        do_reset();
        drive(16'h0, 16'h0, 16'h0010, 16'h0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            $display("mem seq: stall cycle %0d mem_valid=%b", c, bus.mem_valid);
            check($sformatf("mem_stalled_c%0d", c), bus.mem_valid, 32'h0);
        end
        drive(16'h0, 16'h0, 16'h0010, 16'h0, 1'b0, 1'b0);
        tick();
        $display("mem seq: released mem=%b/%h", bus.mem_valid, bus.mem_idx);
        check("mem_after_stall", {bus.mem_valid, bus.mem_idx}, {1'b1, 4'h4});

        // ---------------- flush, then reset over flush ----------------
        do_reset();
        drive(16'h0, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(16'h0, 16'h0001, 16'h0, 16'h0100, 1'b0, 1'b1);
        #1;
        check("flush_keeps_current_mul", bus.mul_valid, 32'h1);
        tick();
        $display("flush seq: bcond=%b busy=%b use=%h", bus.bcond_valid, bus.mul_busy, bus.rs_use_en);
        check("flush_bcond_killed", bus.bcond_valid, 32'h0);
        check("flush_mul_busy_cleared", bus.mul_busy, 32'h0);
        check("flush_use_en", bus.rs_use_en, 32'h0);
        drive(16'h0, 16'h0, 16'h0, 16'h0100, 1'b0, 1'b0);
        tick();
        check("post_flush_bcond", {bus.bcond_valid, bus.bcond_idx}, {1'b1, 4'h8});
        drive(16'h0, 16'h0002, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        check("pre_rst_mul", {bus.mul_valid, bus.mul_idx}, {1'b1, 4'h1});
        rst = 1'b1;
        drive(16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        $display("rst-over-flush: use=%h busy=%b", bus.rs_use_en, bus.mul_busy);
        check("rst_flush_use_en", bus.rs_use_en, 32'h0);
        check("rst_flush_busy", bus.mul_busy, 32'h0);

        // ---------------- pointer advance on the 2-slot ALU ----------------
        do_reset();
        drive(16'h0007, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(16'h0007, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        $display("alu ptr seq: alu_v=%b alu_idx=%h", bus.alu_valid, bus.alu_idx);
`ifdef RS_SCHED_FIXED_PRIO_EN
        check("alu_ptr_second_round", {bus.alu_valid, bus.alu_idx}, {2'b11, 8'h10});
`else
        check("alu_ptr_second_round", {bus.alu_valid, bus.alu_idx}, {2'b11, 8'h02});
`endif

        // ---------------- fairness on the single-slot ALU ----------------
        do_reset();
        prev_idx = -1;
        for (int c = 0; c < 4; c++) begin
            bus1.wake_alu = 16'h8001;
            tick();
            $display("fair seq: cycle %0d alu_v=%b alu_idx=%0d", c, bus1.alu_valid, bus1.alu_idx);
            check($sformatf("fair_valid_c%0d", c), bus1.alu_valid, 32'h1);
            check($sformatf("fair_idx_c%0d", c), bus1.alu_idx, (c % 2 == 0) ? 32'd0 : 32'd15);
            check($sformatf("fair_no_repeat_c%0d", c), (int'(bus1.alu_idx) != prev_idx), 32'h1);
            prev_idx = int'(bus1.alu_idx);
        end
        bus1.wake_alu = 16'h0;

        // ---------------- randomized run against the model ----------------
        do_reset();
        m_ptr = '{0, 0, 0, 0};
        m_cnt = 0;
        m_use = '0;
        for (int n = 0; n < 300; n++) begin
            ra    = 16'($urandom) & 16'($urandom);
            rm    = 16'($urandom) & 16'($urandom);
            re    = 16'($urandom) & 16'($urandom);
            rb    = 16'($urandom) & 16'($urandom);
            st_r  = ($urandom_range(0, 3) == 0);
            fl_r  = ($urandom_range(0, 11) == 0);
            rst_r = ($urandom_range(0, 63) == 0);
            rst   = rst_r;
            drive(ra, rm, re, rb, st_r, fl_r);
            model_step(ra, rm, re, rb, st_r, fl_r, rst_r);
            tick();
            rst = 1'b0;
            $display("rnd %0d: in a=%h m=%h e=%h b=%h st=%b fl=%b rst=%b -> use=%h exp_use=%h busy=%b",
                     n, ra, rm, re, rb, st_r, fl_r, rst_r, bus.rs_use_en, e_use, bus.mul_busy);
            check("rnd_use_en", bus.rs_use_en, e_use);
            check("rnd_alu", {bus.alu_valid, bus.alu_idx}, {e_av, e_ai});
            check("rnd_mul", {bus.mul_valid, bus.mul_idx}, {e_mv, e_mi});
            check("rnd_mem", {bus.mem_valid, bus.mem_idx}, {e_mev, e_mei});
            check("rnd_bcond", {bus.bcond_valid, bus.bcond_idx}, {e_bv, e_bi});
            check("rnd_mul_busy", bus.mul_busy, e_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
